// File: rtl/proc_trace_buffer_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : proc_trace_buffer_if                                         |
// | Description : Snoop inputs and trace drain port of the architectural-state |
// |               trace unit. The "slave" modport is the trace buffer, the     |
// |               "master" modport is the core/debug-host side.                |
// | Options     : TRACE_TIMESTAMP_EN widens trc_data by a 16-bit timestamp.    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
interface proc_trace_buffer_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8,
    parameter int REG_AW = 2,
    parameter int PC_W   = 16,
    parameter int DEPTH  = 16
);
    localparam int c_CNT_W = $clog2(DEPTH + 1);
`ifdef TRACE_TIMESTAMP_EN
    localparam int c_REC_W = 16 + 2 + PC_W + ADDR_W + DATA_W;
`else
    localparam int c_REC_W = 2 + PC_W + ADDR_W + DATA_W;
`endif

    // Snoop side
    logic                 cap_en;
    logic [PC_W-1:0]      pc;
    logic                 rf_wr_en;
    logic [REG_AW-1:0]    rf_wr_addr;
    logic [DATA_W-1:0]    rf_wr_data;
    logic                 mem_wr_en;
    logic [ADDR_W-1:0]    mem_addr;
    logic [DATA_W-1:0]    mem_wr_data;

    // Drain side
    logic                 trc_valid;
    logic                 trc_ready;
    logic [c_REC_W-1:0]   trc_data;
    logic [c_CNT_W-1:0]   trc_count;
    logic                 trc_overflow;

    modport master (
        output cap_en, pc, rf_wr_en, rf_wr_addr, rf_wr_data,
               mem_wr_en, mem_addr, mem_wr_data, trc_ready,
        input  trc_valid, trc_data, trc_count, trc_overflow
    );

    modport slave (
        input  cap_en, pc, rf_wr_en, rf_wr_addr, rf_wr_data,
               mem_wr_en, mem_addr, mem_wr_data, trc_ready,
        output trc_valid, trc_data, trc_count, trc_overflow
    );
endinterface
`default_nettype wire

// File: rtl/proc_trace_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : proc_trace_buffer                                            |
// | Description : Commit-log trace unit. Packs register writebacks and memory  |
// |               stores into {kind, pc, addr, data} records, buffers them in  |
// |               a DEPTH-entry circular store and drains them over a          |
// |               valid/ready port. WRAP_MODE selects drop-new vs overwrite-   |
// |               oldest when full; trc_overflow is sticky until reset.        |
// | Options     : TRACE_TIMESTAMP_EN adds a free-running 16-bit cycle stamp    |
// |               at the MSBs of every record.                                 |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module proc_trace_buffer #(
    parameter int DATA_W    = 16,
    parameter int ADDR_W    = 8,
    parameter int REG_AW    = 2,
    parameter int PC_W      = 16,
    parameter int DEPTH     = 16,
    parameter int WRAP_MODE = 0
) (
    input  wire               clk,
    input  wire               reset,
    proc_trace_buffer_if.slave bus
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = $clog2(DEPTH + 1);
    localparam int c_CW1   = c_CNT_W + 1;
`ifdef TRACE_TIMESTAMP_EN
    localparam int c_TS_W  = 16;
    localparam int c_REC_W = c_TS_W + 2 + PC_W + ADDR_W + DATA_W;
`else
    localparam int c_REC_W = 2 + PC_W + ADDR_W + DATA_W;
`endif
    localparam logic [1:0]       c_KIND_RF  = 2'b01;
    localparam logic [1:0]       c_KIND_MEM = 2'b10;
    localparam logic [c_CW1-1:0] c_DEPTH    = c_CW1'(DEPTH);

    // Storage and state
    logic [c_REC_W-1:0] r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;
    logic               r_overflow;
    logic [c_REC_W-1:0] r_data;
`ifdef TRACE_TIMESTAMP_EN
    logic [c_TS_W-1:0]  r_ts;
`endif

    // Combinational update terms
    logic               w_rf_ev;
    logic               w_mem_ev;
    logic               w_pop;
    logic [1:0]         w_n_ev;
    logic [1:0]         w_n_acc;
    logic [1:0]         w_n_ovw;
    logic               w_drop;
    logic [c_CW1-1:0]   w_free;
    logic [c_CNT_W-1:0] w_count_next;
    logic [c_PTR_W-1:0] w_wr_ptr1;
    logic [c_PTR_W-1:0] w_wr_next;
    logic [c_PTR_W-1:0] w_rd_next;
    logic [REG_AW-1:0]  w_rf_idx;
    logic [c_REC_W-1:0] w_rf_rec;
    logic [c_REC_W-1:0] w_mem_rec;
    logic [c_REC_W-1:0] w_rec0;
    logic [c_REC_W-1:0] w_rec1;
    logic [c_REC_W-1:0] w_head_next;

    // Build the candidate records; RF index is zero-extended into the address field.
    always_comb begin
        w_rf_idx = bus.rf_wr_addr;
`ifdef TRACE_TIMESTAMP_EN
        w_rf_rec  = {r_ts, c_KIND_RF, bus.pc, ADDR_W'(w_rf_idx), bus.rf_wr_data};
        w_mem_rec = {r_ts, c_KIND_MEM, bus.pc, bus.mem_addr, bus.mem_wr_data};
`else
        w_rf_rec  = {c_KIND_RF, bus.pc, ADDR_W'(w_rf_idx), bus.rf_wr_data};
        w_mem_rec = {c_KIND_MEM, bus.pc, bus.mem_addr, bus.mem_wr_data};
`endif
        // RF always occupies the first slot when present, MEM follows it.
        w_rec0 = w_rf_ev ? w_rf_rec : w_mem_rec;
        w_rec1 = w_mem_rec;
    end

    // Decide how many records are accepted, dropped or overwrite old entries.
    always_comb begin
        w_rf_ev  = bus.cap_en & bus.rf_wr_en;
        w_mem_ev = bus.cap_en & bus.mem_wr_en;
        w_pop    = (r_count != '0) & bus.trc_ready;
        w_n_ev   = {1'b0, w_rf_ev} + {1'b0, w_mem_ev};
        // A pop in this cycle frees its slot for the incoming records.
        w_free   = c_DEPTH - {1'b0, r_count} + c_CW1'(w_pop);

        w_n_acc  = w_n_ev;
        w_n_ovw  = 2'd0;
        w_drop   = 1'b0;
        if (c_CW1'(w_n_ev) > w_free) begin
            // free is 0 or 1 here, so its low two bits carry the full value.
            if (WRAP_MODE != 0) begin
                w_n_ovw = w_n_ev - w_free[1:0];
            end else begin
                w_n_acc = w_free[1:0];
                w_drop  = 1'b1;
            end
        end

        w_count_next = r_count + c_CNT_W'(w_n_acc) - c_CNT_W'(w_pop) - c_CNT_W'(w_n_ovw);
        w_wr_ptr1    = r_wr_ptr + c_PTR_W'(1);
        w_wr_next    = r_wr_ptr + c_PTR_W'(w_n_acc);
        // Overwritten records are the oldest ones, so the read side skips past them.
        w_rd_next    = r_rd_ptr + c_PTR_W'(w_pop) + c_PTR_W'(w_n_ovw);
    end

    // Next head record, bypassing records written in this same cycle.
    always_comb begin
        w_head_next = r_mem[w_rd_next];
        if ((w_n_acc != 2'd0) && (w_rd_next == r_wr_ptr)) begin
            w_head_next = w_rec0;
        end else if ((w_n_acc == 2'd2) && (w_rd_next == w_wr_ptr1)) begin
            w_head_next = w_rec1;
        end
        if (w_count_next == '0) begin
            w_head_next = '0;
        end
    end

    // Pointers, occupancy, sticky overflow and the registered head record.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
            r_data     <= '0;
        end else begin
            r_wr_ptr   <= w_wr_next;
            r_rd_ptr   <= w_rd_next;
            r_count    <= w_count_next;
            r_overflow <= r_overflow | w_drop | (w_n_ovw != 2'd0);
            r_data     <= w_head_next;
        end
    end

    // Record store; pointers alone define which entries are live, so no reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (w_n_acc != 2'd0) begin
                r_mem[r_wr_ptr] <= w_rec0;
            end
            if (w_n_acc == 2'd2) begin
                r_mem[w_wr_ptr1] <= w_rec1;
            end
        end
    end

`ifdef TRACE_TIMESTAMP_EN
    // Free-running cycle stamp, wraps naturally at its width.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ts <= '0;
        end else begin
            r_ts <= r_ts + c_TS_W'(1);
        end
    end
`endif

    assign bus.trc_valid    = (r_count != '0);
    assign bus.trc_data     = r_data;
    assign bus.trc_count    = r_count;
    assign bus.trc_overflow = r_overflow;

endmodule
`default_nettype wire
